cmd_decoder_top: RTL and testbench

CMD_DECODER_TOP -- requirements
Module: cmd_decoder_top

---
 rtl/cmd_decoder_pkg.sv | 39 +++
 rtl/cmd_decoder_top_cmd_resp_tx.sv | 83 ++++++++
 rtl/cmd_decoder_top.sv | 195 +++++++++++++++++++
 tb/tb_cmd_decoder_top.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_decoder_pkg.sv
// Shared constants for the Ethernet command decoder: opcodes, frame field
// offsets, status codes and the control FSM state encoding.
package cmd_decoder_pkg;

  localparam int DATA_W  = 8;
  localparam int REG_NUM = 16;
  // Response header bytes carrying real content; the rest is zero padding.
  localparam int HDR_LEN = 27;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam logic [31:0] OP_WRITE = 32'h5757_5757;
  localparam logic [31:0] OP_READ  = 32'h5252_5252;

  localparam logic [7:0] STAT_OK       = 8'h00;
  localparam logic [7:0] STAT_BAD_ADDR = 8'h01;
  localparam logic [7:0] STAT_BAD_OP   = 8'h02;

  localparam logic [7:0] MAX_ADDR = 8'h0F;

  // Received frame byte offsets (inclusive ranges).
  localparam logic [15:0] OFF_DST_END  = 16'd5;
  localparam logic [15:0] OFF_SRC_END  = 16'd11;
  localparam logic [15:0] OFF_TYPE_END = 16'd13;
  localparam logic [15:0] OFF_OP       = 16'd16;
  localparam logic [15:0] OFF_OP_END   = 16'd19;
  localparam logic [15:0] OFF_ID       = 16'd20;
  localparam logic [15:0] OFF_ADDR     = 16'd21;
  localparam logic [15:0] OFF_DATA     = 16'd22;
  localparam logic [15:0] OFF_DATA_END = 16'd25;

  typedef enum logic [1:0] {
    S_RX    = 2'd0,
    S_DRAIN = 2'd1,
    S_EXEC  = 2'd2,
    S_TX    = 2'd3
  } state_e;

endpackage

// File: rtl/cmd_decoder_top_cmd_resp_tx.sv
// Response serializer: walks a byte pointer over the response header and
// zero padding, presenting one byte per AXI-Stream handshake.
module cmd_resp_tx
  import cmd_decoder_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC     = 48'h5a01_0203_0405,
  parameter int          MIN_RESP_LEN = 60
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [47:0]       src_mac_i,
  input  logic [15:0]       ethertype_i,
  input  logic [31:0]       opcode_i,
  input  logic [7:0]        cmd_id_i,
  input  logic [7:0]        addr_i,
  input  logic [31:0]       data_i,
  input  logic [7:0]        status_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tvalid_o,
  output logic              tlast_o,
  input  logic              tready_i,
  output logic              done_o
);

  localparam int                PTR_W    = $clog2(MIN_RESP_LEN);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(MIN_RESP_LEN - 1);
  localparam logic [PTR_W-1:0]  HDR_END  = PTR_W'(HDR_LEN);

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      valid_q, valid_d;
  logic [DATA_W*HDR_LEN-1:0] hdr;
  logic [DATA_W-1:0]         hdr_b [32];
  logic [DATA_W-1:0]         byte_sel;
  logic                      at_last;

  // Header in wire order; byte 0 (reply destination = requester) is the MSB.
  assign hdr = {src_mac_i, FPGA_MAC, ethertype_i, 16'h0000, opcode_i,
                cmd_id_i, addr_i, data_i, status_i};

  // Split the header into an indexable byte table; unused slots read as zero.
  always_comb begin
    for (int i = 0; i < 32; i++) hdr_b[i] = '0;
    for (int i = 0; i < HDR_LEN; i++) hdr_b[i] = hdr[DATA_W*(HDR_LEN-1-i) +: DATA_W];
  end

  assign byte_sel = (ptr_q < HDR_END) ? hdr_b[ptr_q[4:0]] : '0;
  assign at_last  = (ptr_q == LAST_PTR);

  // Pointer/valid update: load on start, advance only on a completed handshake.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    if (start_i) begin
      ptr_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && tready_i) begin
      if (at_last) begin
        ptr_d   = '0;
        valid_d = 1'b0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Serializer state; reset drops valid immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign tvalid_o = valid_q;
  assign tdata_o  = valid_q ? byte_sel : '0;
  assign tlast_o  = valid_q && at_last;
  assign done_o   = valid_q && tready_i && at_last;

endmodule

// File: rtl/cmd_decoder_top.sv
// Ethernet command decoder: parses addressed command frames, executes
// register reads/writes and hands a response to the serializer.
module cmd_decoder_top
  import cmd_decoder_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC     = 48'h5a01_0203_0405,
  parameter int          MIN_RESP_LEN = 60
) (
  input  logic       gtx_tclk_i,
  input  logic       gtx_tresetn_i,
  input  logic       s_axi_aclk,
  input  logic       s_axi_resetn,
  input  logic       clk_fmc150,
  input  logic       resetn_fmc150,
  input  logic [7:0] gpio_dip_sw,
  output logic [7:0] gpio_led,
  input  logic [7:0] rx_axis_tdata,
  input  logic       rx_axis_tvalid,
  input  logic       rx_axis_tlast,
  output logic       rx_axis_tready,
  output logic [7:0] tx_axis_tdata,
  output logic       tx_axis_tvalid,
  output logic       tx_axis_tlast,
  input  logic       tx_axis_tready,
  output logic       frame_error
);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [31:0] op_q, op_d, data_q, data_d, resp_data_q, resp_data_d;
  logic [7:0]  id_q, id_d, addr_q, addr_d, status_q, status_d, cmd_id_q, cmd_id_d;
  logic [31:0] regs_q [REG_NUM];
  logic [31:0] regs_d [REG_NUM];
  logic        frame_error_q, frame_error_d;
  logic        rx_hs, dst_hit, tx_start, tx_done;
  logic [47:0] dst_now;
  logic        unused_ok;

  assign unused_ok = ^{s_axi_aclk, s_axi_resetn, clk_fmc150, resetn_fmc150, gpio_dip_sw[7:1]};

  assign rx_hs   = rx_axis_tvalid && rx_axis_tready;
  // Destination including the byte currently on the bus (complete at byte 5).
  assign dst_now = {dst_q[39:0], rx_axis_tdata};
  assign dst_hit = (dst_now == FPGA_MAC) || (dst_now == BCAST_MAC);

  // FSM state register.
  always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i) begin
    if (gtx_tresetn_i) state_q <= S_RX;
    else               state_q <= state_d;
  end

  // FSM next state: drain foreign frames, execute complete addressed ones.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RX: begin
        if (rx_hs) begin
          if (rx_axis_tlast) begin
            if (idx_q >= OFF_DATA_END) state_d = S_EXEC;
          end else if (idx_q == OFF_DST_END && !dst_hit) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: if (rx_hs && rx_axis_tlast) state_d = S_RX;
      S_EXEC:  state_d = S_TX;
      S_TX:    if (tx_done) state_d = S_RX;
      default: state_d = S_RX;
    endcase
  end

  // FSM outputs: RX accept while receiving/draining, serializer kick in EXEC.
  always_comb begin
    rx_axis_tready = 1'b0;
    tx_start       = 1'b0;
    unique case (state_q)
      S_RX, S_DRAIN: rx_axis_tready = 1'b1;
      S_EXEC:        tx_start       = 1'b1;
      default: ;
    endcase
  end

  // Field capture, frame error detection and command execution.
  always_comb begin
    idx_d         = idx_q;
    dst_d         = dst_q;
    src_d         = src_q;
    type_d        = type_q;
    op_d          = op_q;
    id_d          = id_q;
    addr_d        = addr_q;
    data_d        = data_q;
    resp_data_d   = resp_data_q;
    status_d      = status_q;
    cmd_id_d      = cmd_id_q;
    regs_d        = regs_q;
    frame_error_d = 1'b0;

    if (rx_hs) idx_d = rx_axis_tlast ? 16'd0 : idx_q + 16'd1;

    if (rx_hs && state_q == S_RX) begin
      if (idx_q <= OFF_DST_END)                          dst_d  = dst_now;
      else if (idx_q <= OFF_SRC_END)                     src_d  = {src_q[39:0], rx_axis_tdata};
      else if (idx_q <= OFF_TYPE_END)                    type_d = {type_q[7:0], rx_axis_tdata};
      else if (idx_q >= OFF_OP && idx_q <= OFF_OP_END)   op_d   = {op_q[23:0], rx_axis_tdata};
      else if (idx_q == OFF_ID)                          id_d   = rx_axis_tdata;
      else if (idx_q == OFF_ADDR)                        addr_d = rx_axis_tdata;
      else if (idx_q >= OFF_DATA && idx_q <= OFF_DATA_END) data_d = {data_q[23:0], rx_axis_tdata};

      // Truncated frame that was (or just became) addressed to us.
      if (rx_axis_tlast && idx_q < OFF_DATA_END &&
          (idx_q > OFF_DST_END || (idx_q == OFF_DST_END && dst_hit)))
        frame_error_d = 1'b1;
    end

    if (state_q == S_EXEC) begin
      cmd_id_d = id_q;
      if (op_q != OP_WRITE && op_q != OP_READ) begin
        status_d    = STAT_BAD_OP;
        resp_data_d = '0;
      end else if (addr_q > MAX_ADDR) begin
        status_d    = STAT_BAD_ADDR;
        resp_data_d = '0;
      end else begin
        status_d = STAT_OK;
        if (op_q == OP_WRITE) begin
          regs_d[addr_q[3:0]] = data_q;
          resp_data_d         = data_q;
        end else begin
          resp_data_d = regs_q[addr_q[3:0]];
        end
      end
    end
  end

  // Datapath and register file state; everything clears on reset.
  always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i) begin
    if (gtx_tresetn_i) begin
      idx_q         <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      type_q        <= '0;
      op_q          <= '0;
      id_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      resp_data_q   <= '0;
      status_q      <= '0;
      cmd_id_q      <= '0;
      frame_error_q <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      idx_q         <= idx_d;
      dst_q         <= dst_d;
      src_q         <= src_d;
      type_q        <= type_d;
      op_q          <= op_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      resp_data_q   <= resp_data_d;
      status_q      <= status_d;
      cmd_id_q      <= cmd_id_d;
      frame_error_q <= frame_error_d;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign frame_error = frame_error_q;
  assign gpio_led    = gpio_dip_sw[0] ? regs_q[0][7:0] : cmd_id_q;

  cmd_resp_tx #(
    .FPGA_MAC     (FPGA_MAC),
    .MIN_RESP_LEN (MIN_RESP_LEN)
  ) u_resp_tx (
    .clk_i       (gtx_tclk_i),
    .rst_i       (gtx_tresetn_i),
    .start_i     (tx_start),
    .src_mac_i   (src_q),
    .ethertype_i (type_q),
    .opcode_i    (op_q),
    .cmd_id_i    (id_q),
    .addr_i      (addr_q),
    .data_i      (resp_data_q),
    .status_i    (status_q),
    .tdata_o     (tx_axis_tdata),
    .tvalid_o    (tx_axis_tvalid),
    .tlast_o     (tx_axis_tlast),
    .tready_i    (tx_axis_tready),
    .done_o      (tx_done)
  );

endmodule

// File: tb/tb_cmd_decoder_top.sv
// Directed bench for cmd_decoder_top: frames in, response bytes out.
module tb_cmd_decoder_top;

  localparam logic [47:0] MAC  = 48'h5a01_0203_0405;
  localparam logic [47:0] HOST = 48'h985a_ebdb_066f;
  localparam logic [31:0] OPW  = 32'h5757_5757;
  localparam logic [31:0] OPR  = 32'h5252_5252;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dip;
  logic [7:0] led;
  logic [7:0] rx_tdata;
  logic       rx_tvalid, rx_tlast, rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid, tx_tlast, tx_tready;
  logic       frame_error;

  logic [7:0]  frm   [128];
  logic [7:0]  exp_b [60];
  logic [7:0]  rsp   [128];
  logic [31:0] model_regs [16];
  int rsp_n, rsp_last_idx, rsp_lat, rsp_rx_viol;
  int chk_cnt = 0;
  int pass_cnt = 0;
  int fe_cnt = 0;
  int txv_cnt = 0;

  always #5 clk = ~clk;

  cmd_decoder_top dut (
    .gtx_tclk_i     (clk),
    .gtx_tresetn_i  (rst),
    .s_axi_aclk     (1'b0),
    .s_axi_resetn   (1'b0),
    .clk_fmc150     (1'b0),
    .resetn_fmc150  (1'b0),
    .gpio_dip_sw    (dip),
    .gpio_led       (led),
    .rx_axis_tdata  (rx_tdata),
    .rx_axis_tvalid (rx_tvalid),
    .rx_axis_tlast  (rx_tlast),
    .rx_axis_tready (rx_tready),
    .tx_axis_tdata  (tx_tdata),
    .tx_axis_tvalid (tx_tvalid),
    .tx_axis_tlast  (tx_tlast),
    .tx_axis_tready (tx_tready),
    .frame_error    (frame_error)
  );

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    if (tx_tvalid === 1'b1)   txv_cnt <= txv_cnt + 1;
  end

  function automatic void build_frame(input logic [47:0] dst, input logic [47:0] src,
                                      input logic [15:0] et, input logic [31:0] op,
                                      input logic [7:0] id, input logic [7:0] ad,
                                      input logic [31:0] dat);
    logic [47:0] d, s;
    d = dst; s = src;
    for (int i = 0; i < 128; i++) frm[i] = 8'(i) ^ 8'hC3;
    for (int i = 0; i < 6; i++) begin
      frm[i] = d[47:40]; frm[6+i] = s[47:40];
      d = d << 8; s = s << 8;
    end
    frm[12] = et[15:8];  frm[13] = et[7:0];
    frm[14] = 8'h99;     frm[15] = 8'h99;
    frm[16] = op[31:24]; frm[17] = op[23:16]; frm[18] = op[15:8]; frm[19] = op[7:0];
    frm[20] = id;        frm[21] = ad;
    frm[22] = dat[31:24]; frm[23] = dat[23:16]; frm[24] = dat[15:8]; frm[25] = dat[7:0];
  endfunction

  function automatic void build_exp(input logic [47:0] src, input logic [15:0] et,
                                    input logic [31:0] op, input logic [7:0] id,
                                    input logic [7:0] ad, input logic [31:0] dat,
                                    input logic [7:0] st);
    logic [47:0] s, m;
    s = src; m = MAC;
    for (int i = 0; i < 60; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      exp_b[i] = s[47:40]; exp_b[6+i] = m[47:40];
      s = s << 8; m = m << 8;
    end
    exp_b[12] = et[15:8];  exp_b[13] = et[7:0];
    exp_b[16] = op[31:24]; exp_b[17] = op[23:16]; exp_b[18] = op[15:8]; exp_b[19] = op[7:0];
    exp_b[20] = id;        exp_b[21] = ad;
    exp_b[22] = dat[31:24]; exp_b[23] = dat[23:16]; exp_b[24] = dat[15:8]; exp_b[25] = dat[7:0];
    exp_b[26] = st;
  endfunction

  // Number of response bytes differing from exp_b; first index in 'first'.
  function automatic int resp_diff(output int first);
    int bad = 0;
    first = -1;
    for (int i = 0; i < 60; i++)
      if (rsp[i] !== exp_b[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    return bad;
  endfunction

  task automatic send_frame(input int len);
    int n;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx_tdata = frm[i]; rx_tvalid = 1'b1; rx_tlast = (i == len - 1);
      n = 0;
      while (rx_tready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
        chk_cnt++;
        $display("FAIL rx_accept_timeout: byte %0d not accepted, rx_tready=%b expected 1", i, rx_tready);
      end
      @(posedge clk);
      #1;
    end
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic collect(input int stall);
    bit done = 0;
    rsp_n = 0; rsp_last_idx = -1; rsp_lat = -1; rsp_rx_viol = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (stall != 0) tx_tready = (cyc % 3 != 2);
      if (tx_tvalid === 1'b1 && rsp_lat < 0) rsp_lat = cyc;
      if (tx_tvalid === 1'b1 && rx_tready !== 1'b0) rsp_rx_viol++;
      if (tx_tvalid === 1'b1 && tx_tready === 1'b1) begin
        if (rsp_n < 128) rsp[rsp_n] = tx_tdata;
        if (tx_tlast === 1'b1) begin rsp_last_idx = rsp_n; done = 1; end
        rsp_n++;
      end
    end
    if (done) @(posedge clk);
    #1;
    tx_tready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; dip = 8'hFF; tx_tready = 1'b1;
    rx_tdata = 8'h00; rx_tvalid = 1'b0; rx_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (rx_tready === 1'b1) pass_cnt++; else $display("FAIL reset_rx_tready: got %b want 1", rx_tready);
    chk_cnt++; if (tx_tvalid === 1'b0) pass_cnt++; else $display("FAIL reset_tx_tvalid: got %b want 0", tx_tvalid);
    chk_cnt++; if (tx_tlast === 1'b0) pass_cnt++; else $display("FAIL reset_tx_tlast: got %b want 0", tx_tlast);
    chk_cnt++; if (tx_tdata === 8'h00) pass_cnt++; else $display("FAIL reset_tx_tdata: got %02h want 00", tx_tdata);
    chk_cnt++; if (frame_error === 1'b0) pass_cnt++; else $display("FAIL reset_frame_error: got %b want 0", frame_error);
    chk_cnt++; if (led === 8'h00) pass_cnt++; else $display("FAIL reset_gpio_led: got %02h want 00", led);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    int bad, first;
    build_frame(MAC, HOST, 16'h0022, OPW, 8'h00, 8'h03, 32'h1122_3344);
    build_exp(HOST, 16'h0022, OPW, 8'h00, 8'h03, 32'h1122_3344, 8'h00);
    model_regs[3] = 32'h1122_3344;
    send_frame(64);
    collect(0);
    chk_cnt++; if (rsp_lat == 1) pass_cnt++; else $display("FAIL write_latency: tvalid at cycle %0d want 1", rsp_lat);
    chk_cnt++; if (rsp_n == 60) pass_cnt++; else $display("FAIL write_len: got %0d bytes want 60", rsp_n);
    chk_cnt++; if (rsp_last_idx == 59) pass_cnt++; else $display("FAIL write_tlast: at byte %0d want 59", rsp_last_idx);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0) pass_cnt++;
    else $display("FAIL write_resp: %0d bytes differ, byte %0d got %02h want %02h", bad, first, rsp[first], exp_b[first]);
    chk_cnt++; if (dut.regs_q[3] === 32'h1122_3344) pass_cnt++;
    else $display("FAIL write_reg3: got %08h want 11223344", dut.regs_q[3]);
  endtask

  task automatic test_read;
    int bad, first, rd;
    build_frame(MAC, HOST, 16'h0022, OPR, 8'h01, 8'h03, 32'hFFFF_FFFF);
    build_exp(HOST, 16'h0022, OPR, 8'h01, 8'h03, 32'h1122_3344, 8'h00);
    send_frame(30);
    collect(0);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0 && rsp_n == 60) pass_cnt++;
    else $display("FAIL read_resp: %0d bytes differ (len %0d), first %0d got %02h want %02h", bad, rsp_n, first, rsp[0], exp_b[0]);
    rd = 0;
    for (int i = 0; i < 16; i++) if (dut.regs_q[i] !== model_regs[i]) rd++;
    chk_cnt++; if (rd == 0) pass_cnt++; else $display("FAIL read_regs_unchanged: %0d entries differ, want 0", rd);
  endtask

  task automatic test_not_addressed;
    int fe0, tv0;
    fe0 = fe_cnt; tv0 = txv_cnt;
    build_frame(48'h1122_3344_5566, HOST, 16'h0022, OPW, 8'h0A, 8'h04, 32'h5555_AAAA);
    send_frame(64);
    repeat (80) @(negedge clk);
    chk_cnt++; if (txv_cnt == tv0) pass_cnt++; else $display("FAIL foreign_no_tx: tvalid cycles %0d want 0", txv_cnt - tv0);
    chk_cnt++; if (fe_cnt == fe0) pass_cnt++; else $display("FAIL foreign_no_error: pulses %0d want 0", fe_cnt - fe0);
    chk_cnt++; if (rx_tready === 1'b1) pass_cnt++; else $display("FAIL foreign_rx_ready: got %b want 1", rx_tready);
    chk_cnt++; if (dut.regs_q[4] === 32'h0) pass_cnt++; else $display("FAIL foreign_reg4: got %08h want 00000000", dut.regs_q[4]);
  endtask

  task automatic test_short_frame;
    int fe0, tv0;
    fe0 = fe_cnt; tv0 = txv_cnt;
    build_frame(MAC, HOST, 16'h0022, OPW, 8'h0B, 8'h05, 32'h0BAD_0BAD);
    send_frame(21);
    @(negedge clk);
    chk_cnt++; if (frame_error === 1'b1) pass_cnt++; else $display("FAIL short_error_pulse: got %b want 1", frame_error);
    @(negedge clk);
    chk_cnt++; if (frame_error === 1'b0) pass_cnt++; else $display("FAIL short_error_width: got %b want 0", frame_error);
    repeat (40) @(negedge clk);
    chk_cnt++; if (fe_cnt - fe0 == 1) pass_cnt++; else $display("FAIL short_error_count: got %0d want 1", fe_cnt - fe0);
    chk_cnt++; if (txv_cnt == tv0) pass_cnt++; else $display("FAIL short_no_tx: tvalid cycles %0d want 0", txv_cnt - tv0);
    chk_cnt++; if (dut.regs_q[5] === 32'h0) pass_cnt++; else $display("FAIL short_reg5: got %08h want 00000000", dut.regs_q[5]);
  endtask

  task automatic test_backpressure;
    int bad, first, n, viol;
    tx_tready = 1'b0;
    build_frame(MAC, HOST, 16'h0022, OPW, 8'h05, 8'h07, 32'hDEAD_BEEF);
    build_exp(HOST, 16'h0022, OPW, 8'h05, 8'h07, 32'hDEAD_BEEF, 8'h00);
    model_regs[7] = 32'hDEAD_BEEF;
    send_frame(60);
    n = 0;
    while (tx_tvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk_cnt++; if (n < 20) pass_cnt++; else $display("FAIL bp_tvalid_timeout: tvalid=%b want 1", tx_tvalid);
    viol = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h98 || tx_tlast !== 1'b0 || rx_tready !== 1'b0) viol++;
    end
    chk_cnt++; if (viol == 0) pass_cnt++;
    else $display("FAIL bp_hold: %0d unstable cycles, last tdata %02h want 98", viol, tx_tdata);
    collect(1);
    chk_cnt++; if (rsp_n == 60 && rsp_last_idx == 59) pass_cnt++;
    else $display("FAIL bp_len: got %0d bytes tlast at %0d want 60/59", rsp_n, rsp_last_idx);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0) pass_cnt++;
    else $display("FAIL bp_resp: %0d bytes differ, byte %0d got %02h want %02h", bad, first, rsp[first], exp_b[first]);
    chk_cnt++; if (rsp_rx_viol == 0) pass_cnt++; else $display("FAIL bp_rx_busy: rx_tready high in %0d tx cycles want 0", rsp_rx_viol);
    @(negedge clk);
    chk_cnt++; if (rx_tready === 1'b1) pass_cnt++; else $display("FAIL bp_rx_return: got %b want 1", rx_tready);
  endtask

  task automatic test_gpio;
    int bad, first;
    dip = 8'hFF;
    build_frame(48'hFFFF_FFFF_FFFF, 48'h0a0b_0c0d_0e0f, 16'h0800, OPW, 8'h3C, 8'h00, 32'h0000_00A5);
    build_exp(48'h0a0b_0c0d_0e0f, 16'h0800, OPW, 8'h3C, 8'h00, 32'h0000_00A5, 8'h00);
    model_regs[0] = 32'h0000_00A5;
    send_frame(40);
    collect(0);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0 && rsp_n == 60) pass_cnt++;
    else $display("FAIL bcast_resp: %0d bytes differ (len %0d) want 0", bad, rsp_n);
    @(negedge clk);
    chk_cnt++; if (led === 8'hA5) pass_cnt++; else $display("FAIL gpio_reg0: got %02h want a5", led);
    dip = 8'h00; #1;
    chk_cnt++; if (led === 8'h3C) pass_cnt++; else $display("FAIL gpio_cmd_id: got %02h want 3c", led);
  endtask

  task automatic test_bad_addr;
    int bad, first, rd;
    build_frame(MAC, HOST, 16'h0022, OPW, 8'h44, 8'h20, 32'h1234_5678);
    build_exp(HOST, 16'h0022, OPW, 8'h44, 8'h20, 32'h0000_0000, 8'h01);
    send_frame(30);
    collect(0);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0 && rsp_n == 60) pass_cnt++;
    else $display("FAIL badaddr_resp: %0d bytes differ (len %0d), status got %02h want 01", bad, rsp_n, rsp[26]);
    rd = 0;
    for (int i = 0; i < 16; i++) if (dut.regs_q[i] !== model_regs[i]) rd++;
    chk_cnt++; if (rd == 0) pass_cnt++; else $display("FAIL badaddr_regs: %0d entries changed want 0", rd);
    dip = 8'h00; #1;
    chk_cnt++; if (led === 8'h44) pass_cnt++; else $display("FAIL badaddr_cmd_id: got %02h want 44", led);
  endtask

  task automatic test_bad_opcode;
    int bad, first;
    build_frame(MAC, HOST, 16'h0022, 32'h0102_0304, 8'h66, 8'h03, 32'hABCD_EF01);
    build_exp(HOST, 16'h0022, 32'h0102_0304, 8'h66, 8'h03, 32'h0000_0000, 8'h02);
    send_frame(26);
    collect(0);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0 && rsp_n == 60) pass_cnt++;
    else $display("FAIL badop_resp: %0d bytes differ (len %0d), status got %02h want 02", bad, rsp_n, rsp[26]);
    chk_cnt++; if (dut.regs_q[3] === 32'h1122_3344) pass_cnt++;
    else $display("FAIL badop_reg3: got %08h want 11223344", dut.regs_q[3]);
  endtask

  task automatic test_back_to_back;
    int bad, first;
    build_frame(MAC, HOST, 16'h0022, OPR, 8'h77, 8'h07, 32'h0);
    build_exp(HOST, 16'h0022, OPR, 8'h77, 8'h07, 32'hDEAD_BEEF, 8'h00);
    send_frame(26);
    collect(1);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0 && rsp_n == 60) pass_cnt++;
    else $display("FAIL b2b_first: %0d bytes differ (len %0d) want 0", bad, rsp_n);
    build_frame(MAC, HOST, 16'h0022, OPR, 8'h78, 8'h00, 32'h0);
    build_exp(HOST, 16'h0022, OPR, 8'h78, 8'h00, 32'h0000_00A5, 8'h00);
    send_frame(26);
    collect(0);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0 && rsp_n == 60) pass_cnt++;
    else $display("FAIL b2b_second: %0d bytes differ (len %0d) want 0", bad, rsp_n);
  endtask

  task automatic test_reset_mid;
    int bad, first, n, rd;
    tx_tready = 1'b0;
    build_frame(MAC, HOST, 16'h0022, OPW, 8'h09, 8'h01, 32'hCAFE_F00D);
    send_frame(30);
    n = 0;
    while (tx_tvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (tx_tvalid === 1'b0) pass_cnt++; else $display("FAIL midreset_tvalid: got %b want 0", tx_tvalid);
    chk_cnt++; if (rx_tready === 1'b1) pass_cnt++; else $display("FAIL midreset_rx_tready: got %b want 1", rx_tready);
    dip = 8'hFF;
    @(negedge clk);
    rd = 0;
    for (int i = 0; i < 16; i++) if (dut.regs_q[i] !== 32'h0) rd++;
    chk_cnt++; if (rd == 0) pass_cnt++; else $display("FAIL midreset_regs: %0d entries nonzero want 0", rd);
    chk_cnt++; if (led === 8'h00) pass_cnt++; else $display("FAIL midreset_led: got %02h want 00", led);
    rst = 1'b0; tx_tready = 1'b1;
    repeat (2) @(negedge clk);
    build_frame(MAC, HOST, 16'h0022, OPR, 8'h0C, 8'h01, 32'h0);
    build_exp(HOST, 16'h0022, OPR, 8'h0C, 8'h01, 32'h0000_0000, 8'h00);
    send_frame(26);
    collect(0);
    bad = resp_diff(first);
    chk_cnt++; if (bad == 0 && rsp_n == 60) pass_cnt++;
    else $display("FAIL midreset_readback: %0d bytes differ (len %0d) want 0", bad, rsp_n);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_not_addressed;
    test_short_frame;
    test_backpressure;
    test_gpio;
    test_bad_addr;
    test_bad_opcode;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
